sys_ctrl_tx: RTL and testbench

- Transmit-side stage of the system controller. Sits directly downstream of the receive/command controller and upstream of the UART transmitter.
- Accepts single-cycle "send" requests: an 8-bit register-file read result or a 16-bit ALU result. Queues them and serialises each into bytes.
- Hands bytes to the UART TX through a valid/busy handshake. ALU results go out low byte first, then high byte.

---
 rtl/sys_ctrl_tx_pkg.sv | 25 ++
 rtl/sys_ctrl_tx_if.sv | 42 ++++
 rtl/sys_ctrl_tx_fifo.sv | 70 +++++++
 rtl/sys_ctrl_tx.sv | 150 +++++++++++++++
 tb/tb_sys_ctrl_tx.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_ctrl_tx_pkg.sv
// Shared definitions for the system-controller transmit stage: FSM state
// encoding, queue entry type tags and the queue entry width helper.
package sys_ctrl_tx_pkg;

   localparam logic [1:0] STATE_IDLE      = 2'd0;
   localparam logic [1:0] STATE_LOAD      = 2'd1;
   localparam logic [1:0] STATE_SEND      = 2'd2;
   localparam logic [1:0] STATE_WAIT_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = STATE_IDLE,
      LOAD      = STATE_LOAD,
      SEND      = STATE_SEND,
      WAIT_DONE = STATE_WAIT_DONE
   } tx_state_t;

   localparam logic TYPE_RF  = 1'b0;
   localparam logic TYPE_ALU = 1'b1;

   // A queue entry is {type, payload zero-extended to 2*width}.
   function automatic int entry_width(input int width);
      return 1 + 2 * width;
   endfunction

endpackage

// File: rtl/sys_ctrl_tx_if.sv
// Bundle of request inputs and UART TX handshake signals around the
// transmit stage. The master view is the transmit stage itself; the slave
// view is the surrounding controller plus the UART transmitter.
interface sys_ctrl_tx_if #(
   parameter int WIDTH = 8
);

   logic                   UART_RF_SEND;
   logic [WIDTH-1:0]       UART_SEND_RF_DATA;
   logic                   UART_ALU_SEND;
   logic [2*WIDTH-1:0]     UART_SEND_ALU_DATA;
   logic                   UART_TX_BUSY;
   logic [WIDTH-1:0]       TX_P_DATA;
   logic                   TX_D_VLD;
   logic                   CTRL_TX_BUSY;
   logic                   TX_OVF;

   modport master (
      input  UART_RF_SEND,
      input  UART_SEND_RF_DATA,
      input  UART_ALU_SEND,
      input  UART_SEND_ALU_DATA,
      input  UART_TX_BUSY,
      output TX_P_DATA,
      output TX_D_VLD,
      output CTRL_TX_BUSY,
      output TX_OVF
   );

   modport slave (
      output UART_RF_SEND,
      output UART_SEND_RF_DATA,
      output UART_ALU_SEND,
      output UART_SEND_ALU_DATA,
      output UART_TX_BUSY,
      input  TX_P_DATA,
      input  TX_D_VLD,
      input  CTRL_TX_BUSY,
      input  TX_OVF
   );

endinterface

// File: rtl/sys_ctrl_tx_fifo.sv
// Request queue for the transmit stage. Two push ports (push0 has priority
// over push1) so that simultaneous RF and ALU captures can both be queued,
// one pop port, and a drop pulse whenever a push finds no free slot. DEPTH
// must be a power of two so the pointers wrap naturally.
module sys_ctrl_tx_fifo #(
   parameter int EW    = 17,
   parameter int DEPTH = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         push0,
   input  logic [EW-1:0]                push0_data,
   input  logic                         push1,
   input  logic [EW-1:0]                push1_data,
   input  logic                         pop,
   output logic [EW-1:0]                head,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         drop
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          pop_ok;
   logic          acc0;
   logic          acc1;
   int            free_slots;

   // Decide which pushes fit, counting a same-cycle pop as a freed slot.
   always_comb begin
      pop_ok     = pop && (cnt != '0);
      free_slots = DEPTH - int'(cnt) + (pop_ok ? 1 : 0);
      acc0       = push0 && (free_slots >= 1);
      acc1       = push1 && (free_slots >= (acc0 ? 2 : 1));
      drop       = (push0 && !acc0) || (push1 && !acc1);
   end

   // Storage writes; push1 lands behind push0 when both are accepted.
   always_ff @(posedge CLK) begin
      if (acc0) begin
         mem[wr_ptr] <= push0_data;
      end
      if (acc1) begin
         mem[acc0 ? (wr_ptr + PW'(1)) : wr_ptr] <= push1_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(acc0) + PW'(acc1);
         rd_ptr <= rd_ptr + PW'(pop_ok);
         cnt    <= cnt + CW'(acc0) + CW'(acc1) - CW'(pop_ok);
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (cnt == '0);
   assign count = cnt;

endmodule

// File: rtl/sys_ctrl_tx.sv
// Transmit stage of the system controller. Captures one-cycle RF/ALU send
// requests (payload arrives one cycle after the request), queues them, and
// serialises each entry into bytes for the UART transmitter over a
// valid/busy handshake. ALU results go out low byte first.
module sys_ctrl_tx
   import sys_ctrl_tx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic           CLK,
   input  logic           RST,
   sys_ctrl_tx_if.master  bus
);

   localparam int EW = entry_width(WIDTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic                 pend_rf;
   logic                 pend_alu;
   logic [EW-1:0]        rf_entry;
   logic [EW-1:0]        alu_entry;
   logic [EW-1:0]        fifo_head;
   logic                 fifo_empty;
   logic [CW-1:0]        fifo_count;
   logic                 fifo_drop;
   logic                 fifo_pop;

   tx_state_t            state;
   tx_state_t            state_n;
   logic [2*WIDTH-1:0]   shift_q;
   logic [2*WIDTH-1:0]   shift_n;
   logic [1:0]           cnt_q;
   logic [1:0]           cnt_n;
   logic [WIDTH-1:0]     txd_q;
   logic [WIDTH-1:0]     txd_n;
   logic                 vld_q;
   logic                 vld_n;
   logic                 ovf_q;
   logic                 ovf_n;
   logic                 busy_q;
   logic                 busy_n;

   // Remember which request types arrived so their payloads are taken next cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pend_rf  <= 1'b0;
         pend_alu <= 1'b0;
      end else begin
         pend_rf  <= bus.UART_RF_SEND;
         pend_alu <= bus.UART_ALU_SEND;
      end
   end

   assign rf_entry  = {TYPE_RF, {WIDTH{1'b0}}, bus.UART_SEND_RF_DATA};
   assign alu_entry = {TYPE_ALU, bus.UART_SEND_ALU_DATA};

   sys_ctrl_tx_fifo #(
      .EW    (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK        (CLK),
      .RST        (RST),
      .push0      (pend_rf),
      .push0_data (rf_entry),
      .push1      (pend_alu),
      .push1_data (alu_entry),
      .pop        (fifo_pop),
      .head       (fifo_head),
      .empty      (fifo_empty),
      .count      (fifo_count),
      .drop       (fifo_drop)
   );

   // Register the FSM state and every output so nothing reaches the pins combinationally.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         txd_q   <= '0;
         vld_q   <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_n;
         shift_q <= shift_n;
         cnt_q   <= cnt_n;
         txd_q   <= txd_n;
         vld_q   <= vld_n;
         ovf_q   <= ovf_n;
         busy_q  <= busy_n;
      end
   end

   // Next-state logic: pop an entry, present each byte, and wait out the UART busy round trip.
   always_comb begin
      state_n  = state;
      shift_n  = shift_q;
      cnt_n    = cnt_q;
      txd_n    = txd_q;
      vld_n    = vld_q;
      fifo_pop = 1'b0;
      ovf_n    = ovf_q | fifo_drop;
      busy_n   = (state != IDLE) | (fifo_count != '0) | pend_rf | pend_alu;

      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_n  = fifo_head[2*WIDTH-1:0];
               cnt_n    = (fifo_head[EW-1] == TYPE_ALU) ? 2'd2 : 2'd1;
               state_n  = LOAD;
            end
         end
         LOAD: begin
            txd_n   = shift_q[WIDTH-1:0];
            vld_n   = 1'b1;
            state_n = SEND;
         end
         SEND: begin
            if (bus.UART_TX_BUSY) begin
               vld_n   = 1'b0;
               cnt_n   = cnt_q - 2'd1;
               state_n = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!bus.UART_TX_BUSY) begin
               if (cnt_q != 2'd0) begin
                  shift_n = shift_q >> WIDTH;
                  state_n = LOAD;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: begin
            vld_n   = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   assign bus.TX_P_DATA    = txd_q;
   assign bus.TX_D_VLD     = vld_q;
   assign bus.CTRL_TX_BUSY = busy_q;
   assign bus.TX_OVF       = ovf_q;

endmodule

// File: tb/tb_sys_ctrl_tx.sv
// Directed self-checking bench for sys_ctrl_tx. A small UART TX model
// captures each presented byte, raises busy three cycles later and holds it
// for ten cycles (longer while stall_busy is set).
module tb_sys_ctrl_tx;

   logic CLK;
   logic RST;

   int checks   = 0;
   int failures = 0;

   bit         model_en   = 1'b1;
   bit         stall_busy = 1'b0;
   logic [7:0] rx_q [$];

   sys_ctrl_tx_if #(.WIDTH(8)) bus ();

   sys_ctrl_tx #(
      .WIDTH (8),
      .DEPTH (2)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // UART TX model: take the byte, go busy after 3 cycles, hold 10 cycles or while stalled.
   initial begin : uart_model
      forever begin
         @(posedge CLK);
         #2;
         if (model_en && bus.TX_D_VLD === 1'b1 && !bus.UART_TX_BUSY) begin
            rx_q.push_back(bus.TX_P_DATA);
            repeat (3) begin @(posedge CLK); #2; end
            bus.UART_TX_BUSY = 1'b1;
            repeat (10) begin @(posedge CLK); #2; end
            for (int n = 0; n < 4000 && stall_busy; n++) begin @(posedge CLK); #2; end
            bus.UART_TX_BUSY = 1'b0;
         end
      end
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached (required completion)");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic drive_req(input logic rf, input logic [7:0] rfd,
                            input logic alu, input logic [15:0] alud);
      @(negedge CLK);
      bus.UART_RF_SEND       = rf;
      bus.UART_ALU_SEND      = alu;
      bus.UART_SEND_RF_DATA  = ~rfd;
      bus.UART_SEND_ALU_DATA = ~alud;
      @(negedge CLK);
      bus.UART_RF_SEND       = 1'b0;
      bus.UART_ALU_SEND      = 1'b0;
      if (rf)  bus.UART_SEND_RF_DATA  = rfd;
      if (alu) bus.UART_SEND_ALU_DATA = alud;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      repeat (3) @(negedge CLK);
      bus.UART_SEND_RF_DATA  = 8'hC3;
      bus.UART_SEND_ALU_DATA = 16'hC3C3;
      while (n < 600 && (bus.CTRL_TX_BUSY !== 1'b0 || bus.UART_TX_BUSY || bus.TX_D_VLD !== 1'b0)) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (n >= 600) begin
         failures++;
         $display("[TB] FAIL %s_idle_timeout: still busy after %0d cycles, required idle", name, n);
      end
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      checks++;
      if (bus.TX_D_VLD !== 1'b0) begin failures++; $display("[TB] FAIL reset_vld: got %b, expected 0", bus.TX_D_VLD); end
      checks++;
      if (bus.TX_P_DATA !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %h, expected 00", bus.TX_P_DATA); end
      checks++;
      if (bus.CTRL_TX_BUSY !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.CTRL_TX_BUSY); end
      checks++;
      if (bus.TX_OVF !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %b, expected 0", bus.TX_OVF); end
      RST = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_rf_send();
      int n;
      rx_q.delete();
      drive_req(1'b1, 8'h5A, 1'b0, 16'h0000);
      @(negedge CLK);
      bus.UART_SEND_RF_DATA = 8'hA5;
      @(negedge CLK);
      checks++;
      if (bus.TX_D_VLD !== 1'b0) begin failures++; $display("[TB] FAIL rf_vld_early: got %b at t+3, expected 0", bus.TX_D_VLD); end
      @(negedge CLK);
      checks++;
      if (bus.TX_D_VLD !== 1'b1) begin failures++; $display("[TB] FAIL rf_vld_t4: got %b at t+4, expected 1", bus.TX_D_VLD); end
      checks++;
      if (bus.TX_P_DATA !== 8'h5A) begin failures++; $display("[TB] FAIL rf_data: got %h, expected 5a", bus.TX_P_DATA); end
      checks++;
      if (bus.CTRL_TX_BUSY !== 1'b1) begin failures++; $display("[TB] FAIL rf_ctrl_busy: got %b, expected 1", bus.CTRL_TX_BUSY); end
      n = 0;
      while (n < 50 && !bus.UART_TX_BUSY) begin @(negedge CLK); n++; end
      checks++;
      if (bus.TX_D_VLD !== 1'b1) begin failures++; $display("[TB] FAIL rf_vld_hold: got %b before ack, expected 1", bus.TX_D_VLD); end
      @(negedge CLK);
      checks++;
      if (bus.TX_D_VLD !== 1'b0) begin failures++; $display("[TB] FAIL rf_vld_fall: got %b after ack, expected 0", bus.TX_D_VLD); end
      wait_idle("rf");
      checks++;
      if (rx_q.size() != 1) begin failures++; $display("[TB] FAIL rf_count: got %0d bytes, expected 1", rx_q.size()); end
      checks++;
      if (rx_q.size() < 1 || rx_q[0] !== 8'h5A) begin failures++; $display("[TB] FAIL rf_byte: got %h, expected 5a", (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
      checks++;
      if (bus.CTRL_TX_BUSY !== 1'b0) begin failures++; $display("[TB] FAIL rf_busy_end: got %b, expected 0", bus.CTRL_TX_BUSY); end
   endtask

   task automatic test_alu_send();
      logic [7:0] exp [2];
      logic [7:0] got;
      exp = '{8'hEF, 8'hBE};
      rx_q.delete();
      drive_req(1'b0, 8'h00, 1'b1, 16'hBEEF);
      wait_idle("alu");
      checks++;
      if (rx_q.size() != 2) begin failures++; $display("[TB] FAIL alu_count: got %0d bytes, expected 2", rx_q.size()); end
      for (int i = 0; i < 2; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         checks++;
         if (got !== exp[i]) begin failures++; $display("[TB] FAIL alu_byte%0d: got %h, expected %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [3];
      logic [7:0] got;
      exp = '{8'h34, 8'h12, 8'h77};
      rx_q.delete();
      drive_req(1'b0, 8'h00, 1'b1, 16'h1234);
      drive_req(1'b1, 8'h77, 1'b0, 16'h0000);
      wait_idle("b2b");
      checks++;
      if (rx_q.size() != 3) begin failures++; $display("[TB] FAIL b2b_count: got %0d bytes, expected 3", rx_q.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         checks++;
         if (got !== exp[i]) begin failures++; $display("[TB] FAIL b2b_byte%0d: got %h, expected %h", i, got, exp[i]); end
      end
      checks++;
      if (bus.TX_OVF !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ovf: got %b, expected 0", bus.TX_OVF); end
   endtask

   task automatic test_simultaneous();
      logic [7:0] exp [3];
      logic [7:0] got;
      exp = '{8'hAA, 8'hCC, 8'h00};
      rx_q.delete();
      drive_req(1'b1, 8'hAA, 1'b1, 16'h00CC);
      wait_idle("dual");
      checks++;
      if (rx_q.size() != 3) begin failures++; $display("[TB] FAIL dual_count: got %0d bytes, expected 3", rx_q.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         checks++;
         if (got !== exp[i]) begin failures++; $display("[TB] FAIL dual_byte%0d: got %h, expected %h", i, got, exp[i]); end
      end
      checks++;
      if (bus.TX_OVF !== 1'b0) begin failures++; $display("[TB] FAIL dual_ovf: got %b, expected 0", bus.TX_OVF); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp [3];
      logic [7:0] got;
      exp = '{8'h01, 8'h02, 8'h03};
      rx_q.delete();
      stall_busy = 1'b1;
      drive_req(1'b1, 8'h01, 1'b0, 16'h0000);
      drive_req(1'b1, 8'h02, 1'b0, 16'h0000);
      drive_req(1'b1, 8'h03, 1'b0, 16'h0000);
      repeat (2) @(negedge CLK);
      checks++;
      if (bus.TX_OVF !== 1'b0) begin failures++; $display("[TB] FAIL ovf_before_full: got %b, expected 0", bus.TX_OVF); end
      drive_req(1'b1, 8'h04, 1'b0, 16'h0000);
      repeat (2) @(negedge CLK);
      checks++;
      if (bus.TX_OVF !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set: got %b, expected 1", bus.TX_OVF); end
      stall_busy = 1'b0;
      wait_idle("ovf");
      checks++;
      if (rx_q.size() != 3) begin failures++; $display("[TB] FAIL ovf_count: got %0d bytes, expected 3", rx_q.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         checks++;
         if (got !== exp[i]) begin failures++; $display("[TB] FAIL ovf_byte%0d: got %h, expected %h", i, got, exp[i]); end
      end
      checks++;
      if (bus.TX_OVF !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky: got %b, expected 1", bus.TX_OVF); end
   endtask

   task automatic test_reset_mid_frame();
      int n;
      model_en = 1'b0;
      bus.UART_TX_BUSY = 1'b0;
      rx_q.delete();
      drive_req(1'b1, 8'h99, 1'b0, 16'h0000);
      n = 0;
      while (n < 20 && bus.TX_D_VLD !== 1'b1) begin @(negedge CLK); n++; end
      @(negedge CLK);
      checks++;
      if (bus.TX_D_VLD !== 1'b1 || bus.TX_P_DATA !== 8'h99) begin
         failures++;
         $display("[TB] FAIL rst_mid_send: got vld=%b data=%h, expected vld=1 data=99", bus.TX_D_VLD, bus.TX_P_DATA);
      end
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      checks++;
      if (bus.TX_D_VLD !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_vld: got %b, expected 0", bus.TX_D_VLD); end
      checks++;
      if (bus.TX_OVF !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_ovf: got %b, expected 0", bus.TX_OVF); end
      checks++;
      if (bus.CTRL_TX_BUSY !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy: got %b, expected 0", bus.CTRL_TX_BUSY); end
      checks++;
      if (bus.TX_P_DATA !== 8'h00) begin failures++; $display("[TB] FAIL rst_mid_data: got %h, expected 00", bus.TX_P_DATA); end
      repeat (6) @(negedge CLK);
      checks++;
      if (bus.TX_D_VLD !== 1'b0 || bus.CTRL_TX_BUSY !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rst_mid_abandon: got vld=%b busy=%b, expected 0 0", bus.TX_D_VLD, bus.CTRL_TX_BUSY);
      end
      model_en = 1'b1;
      rx_q.delete();
      drive_req(1'b1, 8'h11, 1'b0, 16'h0000);
      wait_idle("rst_after");
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h11) begin
         failures++;
         $display("[TB] FAIL rst_after_byte: got %0d bytes first=%h, expected 1 byte 11", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
      end
   endtask

   // Test sequence.
   initial begin : main
      RST                    = 1'b1;
      bus.UART_RF_SEND       = 1'b0;
      bus.UART_ALU_SEND      = 1'b0;
      bus.UART_SEND_RF_DATA  = 8'h00;
      bus.UART_SEND_ALU_DATA = 16'h0000;
      bus.UART_TX_BUSY       = 1'b0;

      test_reset();
      $display("[TB] rf send");
      test_rf_send();
      $display("[TB] alu send");
      test_alu_send();
      $display("[TB] back to back");
      test_back_to_back();
      $display("[TB] simultaneous requests");
      test_simultaneous();
      $display("[TB] overflow");
      test_overflow();
      $display("[TB] reset mid frame");
      test_reset_mid_frame();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
